// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: accepts a WIDTH-bit word and streams it one bit
// per clock on a registered inbits/bit_valid pair, with back-to-back word support.
module bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             inbits,
    output logic             bit_valid,
    output logic             done
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             inbits_q, inbits_d;
    logic             bit_valid_q, bit_valid_d;
    logic             done_q, done_d;

    logic             last_bit;
    logic             accept;
    logic             first_bit;
    logic [WIDTH-1:0] load_rest;
    logic             next_bit;
    logic [WIDTH-1:0] shifted;

    // The first bit goes straight to inbits on load; the register holds the rest.
    generate
        if (MSB_FIRST) begin : g_msb
            assign first_bit = data_in[WIDTH-1];
            assign load_rest = {data_in[WIDTH-2:0], 1'b0};
            assign next_bit  = shreg_q[WIDTH-1];
            assign shifted   = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign first_bit = data_in[0];
            assign load_rest = {1'b0, data_in[WIDTH-1:1]};
            assign next_bit  = shreg_q[0];
            assign shifted   = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign last_bit = (state_q == SHIFT) && (idx_q == LAST_IDX);
    assign ready    = !reset && ((state_q == IDLE) || last_bit);
    assign accept   = load && ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        inbits_d    = 1'b0;
        bit_valid_d = 1'b0;
        done_d      = 1'b0;
        if (accept) begin
            state_d     = SHIFT;
            idx_d       = '0;
            shreg_d     = load_rest;
            inbits_d    = first_bit;
            bit_valid_d = 1'b1;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                idx_d   = '0;
                shreg_d = '0;
            end else begin
                idx_d       = idx_q + IDX_W'(1);
                shreg_d     = shifted;
                inbits_d    = next_bit;
                bit_valid_d = 1'b1;
                done_d      = ((idx_q + IDX_W'(1)) == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shreg_q     <= '0;
            inbits_q    <= 1'b0;
            bit_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            inbits_q    <= inbits_d;
            bit_valid_q <= bit_valid_d;
            done_q      <= done_d;
        end
    end

    assign inbits    = inbits_q;
    assign bit_valid = bit_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Drives an MSB-first and an LSB-first serializer with shared stimulus and checks
// every cycle against a queue-of-pending-bits reference model.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] data_in;
    logic         load;

    logic ready_m, inbits_m, bit_valid_m, done_m;
    logic ready_l, inbits_l, bit_valid_l, done_l;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Bits still to be presented, front = bit currently on inbits.
    logic q_msb[$];
    logic q_lsb[$];

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .load     (load),
        .ready    (ready_m),
        .inbits   (inbits_m),
        .bit_valid(bit_valid_m),
        .done     (done_m)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .load     (load),
        .ready    (ready_l),
        .inbits   (inbits_l),
        .bit_valid(bit_valid_l),
        .done     (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic compare_all();
        logic exp_rdy;
        exp_rdy = !reset && (q_msb.size() <= 1);
        check("msb_ready",     {31'b0, ready_m},     {31'b0, exp_rdy});
        check("msb_bit_valid", {31'b0, bit_valid_m}, {31'b0, q_msb.size() > 0});
        check("msb_inbits",    {31'b0, inbits_m},    {31'b0, (q_msb.size() > 0) ? q_msb[0] : 1'b0});
        check("msb_done",      {31'b0, done_m},      {31'b0, q_msb.size() == 1});
        check("lsb_ready",     {31'b0, ready_l},     {31'b0, exp_rdy});
        check("lsb_bit_valid", {31'b0, bit_valid_l}, {31'b0, q_lsb.size() > 0});
        check("lsb_inbits",    {31'b0, inbits_l},    {31'b0, (q_lsb.size() > 0) ? q_lsb[0] : 1'b0});
        check("lsb_done",      {31'b0, done_l},      {31'b0, q_lsb.size() == 1});
    endtask

    // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
    task automatic step(input logic ld, input logic [W-1:0] d);
        logic rdy;
        logic dummy;
        load    = ld;
        data_in = d;
        @(posedge clk);
        rdy = !reset && (q_msb.size() <= 1);
        if (reset) begin
            q_msb.delete();
            q_lsb.delete();
        end else begin
            if (q_msb.size() > 0) dummy = q_msb.pop_front();
            if (q_lsb.size() > 0) dummy = q_lsb.pop_front();
            if (ld && rdy) begin
                for (int i = 0; i < W; i++) begin
                    q_msb.push_back(d[W-1-i]);
                    q_lsb.push_back(d[i]);
                end
                $display("[TB] cycle %0d: word %02h accepted", cyc, d);
            end
        end
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
    endtask

    initial begin
        reset   = 1'b0;
        load    = 1'b0;
        data_in = '0;
        #2 reset = 1'b1;
        #1 compare_all();
        @(negedge clk);
        step(1'b1, 8'h5A);
        step(1'b0, 8'h00);
        reset = 1'b0;
        #1 compare_all();

        // Load on the first edge after release; MSB stream 1,0,1,1,0,1,0,1
        step(1'b1, 8'hB5);
        idle_cycles(W - 1);
        idle_cycles(2);

        // Back-to-back: 8'hFF then 8'h00 accepted on the done cycle
        step(1'b1, 8'hFF);
        idle_cycles(W - 1);
        step(1'b1, 8'h00);
        idle_cycles(W - 1);
        idle_cycles(2);

        // Load held high during a word: only the done-cycle load is taken
        step(1'b1, 8'hA0);
        for (int i = 0; i < W; i++) step(1'b1, 8'h0F);
        idle_cycles(W + 1);

        // Reset after the third bit discards the rest of the word
        step(1'b1, 8'hC3);
        idle_cycles(2);
        reset = 1'b1;
        #1;
        q_msb.delete();
        q_lsb.delete();
        compare_all();
        step(1'b1, 8'h77);
        step(1'b0, 8'h00);
        reset = 1'b0;
        #1 compare_all();

        // Idle with toggling data
        idle_cycles(10);

        // Single 8'h01 word exercises the first-bit ordering of both instances
        step(1'b1, 8'h01);
        idle_cycles(W + 1);

        // Randomized load pattern
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 2) == 0), W'($urandom));
        end
        idle_cycles(W + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: bits per word; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 means MSB shifted first; 0 means LSB shifted first.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port data_in  input  WIDTH  parallel word to serialize; sampled only on an accepted load.
REQ-006 Port load  input  1  word-valid strobe; the word is accepted when load=1 and ready=1 at a rising edge.
REQ-007 Port ready  output  1  block can accept a word this cycle.
REQ-008 Port inbits  output  1  serial bit stream for the downstream sequence detector; driven from a register.
REQ-009 Port bit_valid  output  1  inbits carries a valid data bit this cycle; driven from a register.
REQ-010 Port done  output  1  one-cycle pulse, high while the last bit of a word is presented.

Function
REQ-011 The FSM SHALL have two states: IDLE and SHIFT.
REQ-012 In IDLE, the block SHALL hold inbits=0, bit_valid=0, done=0 and ready=1.
REQ-013 An accepted load in IDLE SHALL capture data_in, set the bit index to 0 and enter SHIFT.
REQ-014 On the cycle after acceptance, the first bit (bit WIDTH-1 if MSB_FIRST=1, else bit 0) SHALL be on inbits with bit_valid=1; load-to-first-bit latency is exactly 1 clock.
REQ-015 In SHIFT, each rising edge SHALL present the next bit and increment the bit index, so all WIDTH bits appear on WIDTH consecutive cycles with no gaps.
REQ-016 The bit index SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.
REQ-017 done SHALL be 1 only on the cycle the bit with index WIDTH-1 is presented.
REQ-018 ready SHALL be 0 in SHIFT, except on the last-bit cycle (index WIDTH-1), where it SHALL be 1.
REQ-019 Back-to-back case: a load accepted on the last-bit cycle SHALL capture the new word and remain in SHIFT, with its first bit on the next cycle. bit_valid SHALL stay 1 continuously.
REQ-020 If no load is accepted on the last-bit cycle, the FSM SHALL return to IDLE on the next edge, and outputs SHALL take the IDLE values of REQ-012.
REQ-021 A load asserted while ready=0 SHALL be ignored. data_in SHALL have no effect, and the word in flight SHALL be unaffected.
REQ-022 Changes on data_in while no load is accepted SHALL have no effect on any output.
REQ-023 bit_valid=0 SHALL always imply inbits=0.

Reset
REQ-024 While reset=1, the block SHALL asynchronously force state=IDLE, bit index=0, shift register=0, inbits=0, bit_valid=0 and done=0.
REQ-025 During reset=1, ready SHALL read 0. ready SHALL be 1 from the first cycle after reset deasserts.
REQ-026 Reset asserted mid-word SHALL discard the remaining bits; no partial word SHALL resume after release.
REQ-027 A load on the first edge after reset release SHALL be accepted normally.

Verification
REQ-028 Scenario: WIDTH=8, MSB_FIRST=1, load 8'hB5 from IDLE -> inbits=1,0,1,1,0,1,0,1 on 8 consecutive cycles starting 1 clock after the load edge. bit_valid=1 throughout, done=1 on the 8th bit only, then IDLE.
REQ-029 Scenario: load 8'hFF, then load 8'h00 on the done cycle -> 16 contiguous bit_valid cycles: eight 1s then eight 0s. done pulses on cycles 8 and 16.
REQ-030 Scenario: load 8'hA0, then hold load=1 with data_in=8'h0F during bits 1..7 -> output is exactly 1,0,1,0,0,0,0,0. When load stays high at the done cycle, 8'h0F is accepted then and streams next.
REQ-031 Scenario: load 8'hC3, then assert reset after the 3rd bit -> inbits, bit_valid and done are 0 immediately (asynchronous). After release, ready=1 and no remaining bits of 8'hC3 appear.
REQ-032 Scenario: MSB_FIRST=0, load 8'h01 -> inbits=1,0,0,0,0,0,0,0.
REQ-033 Scenario: idle with load=0 for 10 cycles while data_in toggles -> bit_valid, inbits and done stay 0, and ready stays 1.
